// File: rtl/vending_machine_param.sv
// Parametrised vending controller: N_ITEMS products priced from a packed table,
// 10/50 coins, bounded credit, one-coin-per-cycle change and refund pulses.
module vending_machine_param #(
  parameter int N_ITEMS  = 4,
  parameter int ITEM_W   = 2,
  parameter int CREDIT_W = 5,
  parameter int MAX_CREDIT = 9,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICE_TABLE = {5'd5, 5'd4, 5'd3, 5'd2}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ITEM_W-1:0]   item,
  input  logic                sel,
  input  logic                coin_10,
  input  logic                coin_50,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] price_left,
  output logic [ITEM_W:0]     item_rels,
  output logic                change_return,
  output logic                coin_reject,
  output logic                busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] VEND    = 2'd2;
  localparam logic [1:0] CHANGE  = 2'd3;

  localparam logic [CREDIT_W:0]   MAX_W  = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   FIVE_W = (CREDIT_W+1)'(5);
  localparam logic [CREDIT_W:0]   ONE_W  = (CREDIT_W+1)'(1);
  localparam logic [CREDIT_W-1:0] FIVE_C = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] ONE_C  = CREDIT_W'(1);

  // Handshake-free block: every input is a single-cycle strobe sampled at the
  // rising edge; every pulse output is valid for exactly the following cycle.

  logic [1:0]          state_q,     state_d;
  logic [CREDIT_W-1:0] credit_q,    credit_d;
  logic                sel_valid_q, sel_valid_d;
  logic [ITEM_W-1:0]   sel_idx_q,   sel_idx_d;
  logic [CREDIT_W-1:0] change_q,    change_d;
  logic                reject_q,    reject_d;

  logic                coin_any;
  logic                ok50;
  logic                ok10;
  logic [CREDIT_W-1:0] cr50;
  logic [CREDIT_W-1:0] new_credit;
  logic [CREDIT_W-1:0] new_price;
  logic [CREDIT_W-1:0] price_sel;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [ITEM_W-1:0] idx);
    logic [CREDIT_W-1:0] p;
    p = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (idx == ITEM_W'(i)) p = PRICE_TABLE[i*CREDIT_W +: CREDIT_W];
    end
    return p;
  endfunction

  // Indices beyond N_ITEMS (non power-of-two tables) are not selectable.
  function automatic logic item_ok(input logic [ITEM_W-1:0] idx);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (idx == ITEM_W'(i)) ok = 1'b1;
    end
    return ok;
  endfunction

  assign coin_any = coin_10 | coin_50;

  // Coin acceptance: the 50 is tried first; an accepted 50 always bumps a
  // simultaneous 10, a rejected 50 leaves the 10 free to be tried on its own.
  always_comb begin
    ok50 = coin_50 && (({1'b0, credit_q} + FIVE_W) <= MAX_W);
    cr50 = ok50 ? (credit_q + FIVE_C) : credit_q;
    ok10 = coin_10 && !ok50 && (({1'b0, cr50} + ONE_W) <= MAX_W);
    new_credit = ok10 ? (cr50 + ONE_C) : cr50;
  end

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    sel_valid_d = sel_valid_q;
    sel_idx_d   = sel_idx_q;
    change_d    = change_q;
    reject_d    = 1'b0;
    new_price   = '0;
    case (state_q)
      IDLE, COLLECT: begin
        if (cancel && state_q == COLLECT) begin
          reject_d    = coin_any;
          sel_valid_d = 1'b0;
          if (credit_q != '0) begin
            change_d = credit_q;
            credit_d = '0;
            state_d  = CHANGE;
          end else begin
            state_d  = IDLE;
          end
        end else begin
          reject_d = (coin_50 && !ok50) || (coin_10 && !ok10);
          if (sel && item_ok(item)) begin
            sel_valid_d = 1'b1;
            sel_idx_d   = item;
          end
          new_price = price_of(sel_idx_d);
          if (sel_valid_d && new_credit >= new_price) begin
            change_d = new_credit - new_price;
            credit_d = '0;
            state_d  = VEND;
          end else begin
            credit_d = new_credit;
            state_d  = (new_credit != '0 || sel_valid_d) ? COLLECT : IDLE;
          end
        end
      end
      VEND: begin
        reject_d    = coin_any;
        sel_valid_d = 1'b0;
        state_d     = (change_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_d = coin_any;
        change_d = change_q - ONE_C;
        if (change_q <= ONE_C) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      sel_valid_q <= 1'b0;
      sel_idx_q   <= '0;
      change_q    <= '0;
      reject_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      sel_valid_q <= sel_valid_d;
      sel_idx_q   <= sel_idx_d;
      change_q    <= change_d;
      reject_q    <= reject_d;
    end
  end

  assign price_sel     = price_of(sel_idx_q);
  assign credit        = credit_q;
  assign price_left    = (sel_valid_q && price_sel > credit_q) ? (price_sel - credit_q) : '0;
  assign item_rels     = (state_q == VEND) ? {1'b1, sel_idx_q} : '0;
  assign change_return = (state_q == CHANGE);
  assign coin_reject   = reject_q;
  assign busy          = (state_q == VEND) || (state_q == CHANGE);

endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param: directed scenarios plus random traffic, all
// outputs checked each cycle against a queue-based transaction model.
module tb_vending_machine_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] item = '0;
  logic       sel = 1'b0;
  logic       coin_10 = 1'b0;
  logic       coin_50 = 1'b0;
  logic       cancel = 1'b0;
  logic [4:0] credit;
  logic [4:0] price_left;
  logic [2:0] item_rels;
  logic       change_return;
  logic       coin_reject;
  logic       busy;

  vending_machine_param dut (
    .clk(clk), .reset(reset), .item(item), .sel(sel),
    .coin_10(coin_10), .coin_50(coin_50), .cancel(cancel),
    .credit(credit), .price_left(price_left), .item_rels(item_rels),
    .change_return(change_return), .coin_reject(coin_reject), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: credit/selection plus a plan of upcoming busy cycles.
  // plan[0] is the frame shown this cycle: >=0 vend of that index, -1 one change coin.
  int price_tab[4] = '{2, 3, 4, 5};
  int m_credit = 0;
  bit m_sv = 1'b0;
  int m_idx = 0;
  bit m_rej = 1'b0;
  int plan[$];
  int cr;
  bit took50;

  always @(posedge clk) begin
    m_rej = 1'b0;
    if (reset) begin
      m_credit = 0; m_sv = 1'b0; m_idx = 0;
      plan.delete();
    end else if (plan.size() > 0) begin
      m_rej = coin_10 | coin_50;
      if (plan[0] >= 0) m_sv = 1'b0;
      void'(plan.pop_front());
    end else if (cancel && (m_credit > 0 || m_sv)) begin
      m_rej = coin_10 | coin_50;
      m_sv = 1'b0;
      for (int i = 0; i < m_credit; i++) plan.push_back(-1);
      m_credit = 0;
    end else begin
      cr = m_credit;
      took50 = 1'b0;
      if (coin_50) begin
        if (cr + 5 <= 9) begin cr += 5; took50 = 1'b1; end
        else m_rej = 1'b1;
      end
      if (coin_10) begin
        if (took50 || cr + 1 > 9) m_rej = 1'b1;
        else cr += 1;
      end
      if (sel) begin m_sv = 1'b1; m_idx = int'(item); end
      if (m_sv && cr >= price_tab[m_idx]) begin
        plan.push_back(m_idx);
        for (int i = 0; i < cr - price_tab[m_idx]; i++) plan.push_back(-1);
        m_credit = 0;
      end else begin
        m_credit = cr;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int e_item, e_pl;
      e_item = (plan.size() > 0 && plan[0] >= 0) ? (4 + plan[0]) : 0;
      e_pl = (m_sv && price_tab[m_idx] > m_credit) ? price_tab[m_idx] - m_credit : 0;
      chk("model_item_rels", int'(item_rels), e_item);
      chk("model_change_return", int'(change_return), (plan.size() > 0 && plan[0] < 0) ? 1 : 0);
      chk("model_busy", int'(busy), (plan.size() > 0) ? 1 : 0);
      chk("model_credit", int'(credit), m_credit);
      chk("model_price_left", int'(price_left), e_pl);
      chk("model_coin_reject", int'(coin_reject), int'(m_rej));
    end
  end

  task automatic step(input bit s, input int it, input bit c10, input bit c50,
                      input bit can, input bit rst);
    sel = s; item = 2'(it); coin_10 = c10; coin_50 = c50; cancel = can; reset = rst;
    @(posedge clk);
    #1;
    sel = 1'b0; item = '0; coin_10 = 1'b0; coin_50 = 1'b0; cancel = 1'b0; reset = 1'b0;
  endtask

  task automatic run_idle(input int n, output int pulses, output int vends);
    pulses = 0; vends = 0;
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      pulses += int'(change_return);
      vends += int'(item_rels[2]);
    end
  endtask

  int p, v, p0;

  initial begin
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_credit", int'(credit), 0);
    chk("reset_outputs", int'({item_rels, change_return, coin_reject, busy}), 0);

    // Exact payment, item 0
    step(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1_price_left_sel", int'(price_left), 2);
    step(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("t1_price_left_1coin", int'(price_left), 1);
    step(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("t1_item_rels", int'(item_rels), 3'b100);
    chk("t1_busy", int'(busy), 1);
    chk("t1_credit", int'(credit), 0);
    chk("t1_no_change", int'(change_return), 0);
    run_idle(3, p, v);
    chk("t1_change_pulses", p, 0);
    chk("t1_busy_end", int'(busy), 0);

    // Change, item 1
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("t2_item_rels", int'(item_rels), 3'b101);
    chk("t2_model_plan", plan.size(), 3);
    run_idle(4, p, v);
    chk("t2_change_pulses", p, 2);
    chk("t2_busy_end", int'(busy), 0);

    // Cancel refund
    repeat (3) step(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("t3_credit_before", int'(credit), 3);
    step(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("t3_credit_after", int'(credit), 0);
    p0 = int'(change_return);
    run_idle(5, p, v);
    chk("t3_refund_pulses", p + p0, 3);
    chk("t3_no_vend", v, 0);

    // Overflow and simultaneous coins
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    @(negedge clk);
    chk("t4_credit_6", int'(credit), 6);
    chk("t4_reject_both", int'(coin_reject), 1);
    repeat (3) step(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("t4_credit_9", int'(credit), 9);
    chk("t4_model_credit", m_credit, 9);
    chk("t4_no_reject", int'(coin_reject), 0);
    step(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("t4_credit_held", int'(credit), 9);
    chk("t4_reject_full", int'(coin_reject), 1);
    step(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    p0 = int'(change_return);
    run_idle(10, p, v);
    chk("t4_refund_pulses", p + p0, 9);

    // Coins while busy, item 3
    step(0, 0, 0, 1, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5_item_rels", int'(item_rels), 3'b111);
    p = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, 0, i == 1, 0, 0, 0);
      @(negedge clk);
      p += int'(change_return);
      if (i == 1) begin
        chk("t5_reject_busy", int'(coin_reject), 1);
        chk("t5_credit_busy", int'(credit), 0);
      end
    end
    chk("t5_change_pulses", p, 4);

    // Reset during second change pulse
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t6_second_pulse", int'(change_return), 1);
    step(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("t6_after_reset", int'({credit, price_left, item_rels, change_return, coin_reject, busy}), 0);
    run_idle(4, p, v);
    chk("t6_no_pulses", p, 0);
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("t6_new_vend", int'(item_rels), 3'b110);
    run_idle(3, p, v);
    chk("t6_new_change", p, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 3),
           $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    #1;
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
